rptr_empty: RTL and testbench



---
 rtl/fifo_pkg.sv | 37 +++
 rtl/rptr_empty_if.sv | 34 +++
 rtl/rptr_empty.sv | 71 +++++++
 tb/tb_rptr_empty.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the asynchronous FIFO (read-side empty logic and
// write-side full logic).
//   ptr_width(aw) : pointer width for a FIFO with 2**aw entries (aw+1 bits)
//   depth_of(aw)  : number of entries for address width aw
//   bin2gray(b)   : binary -> reflected Gray
//   gray2bin(g)   : reflected Gray -> binary
// The conversions work on a MAX_PTR_W-bit container. Callers zero-extend a
// narrower pointer into it and truncate the result back. Zero upper bits
// leave both conversions exact, so one function pair serves every pointer
// width.
package fifo_pkg;

    localparam int MAX_PTR_W = 32;

    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Bit k of the binary value is the XOR of all Gray bits at and above k.
    function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
        logic [MAX_PTR_W-1:0] b;
        b = g;
        for (int i = 1; i < MAX_PTR_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/rptr_empty_if.sv
// Read-side bus of the asynchronous FIFO pointer logic.
//   rinc           : read request from the consumer
//   wptr_gray_sync : write Gray pointer, already synchronised to rclk
//   rempty         : FIFO empty (registered)
//   ralmost_empty  : occupancy <= threshold (registered)
//   raddr          : RAM read address
//   rptr_gray      : Gray read pointer sent to the write domain
//   rlevel         : occupancy seen from the read domain
//   runderflow     : one-cycle pulse after a rinc issued while empty
// Handshake: rinc acts as valid and ~rempty acts as ready. A read transfers
// on a rising rclk edge where rinc = 1 and rempty = 0. A rinc while rempty = 1
// is dropped and reported on runderflow.
interface rptr_empty_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  rinc;
    logic [ADDR_WIDTH:0]   wptr_gray_sync;
    logic                  rempty;
    logic                  ralmost_empty;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [ADDR_WIDTH:0]   rptr_gray;
    logic [ADDR_WIDTH:0]   rlevel;
    logic                  runderflow;

    modport master (
        output rinc, wptr_gray_sync,
        input  rempty, ralmost_empty, raddr, rptr_gray, rlevel, runderflow
    );

    modport slave (
        input  rinc, wptr_gray_sync,
        output rempty, ralmost_empty, raddr, rptr_gray, rlevel, runderflow
    );
endinterface

// File: rtl/rptr_empty.sv
// Read-domain pointer and empty-flag logic of the asynchronous FIFO.
//   rclk   : read clock
//   rrst_n : asynchronous active-low reset
//   bus    : rptr_empty_if slave modport (request, synced write pointer, flags,
//            read address, Gray read pointer, level, underflow pulse)
// Every output is a flop, or a slice of one, so no input reaches an output
// combinationally. Flags and level are computed from next-state pointers.
// A read and a write-pointer change in the same cycle are therefore both
// seen at that edge.
module rptr_empty
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int AE_THRESH  = 1
) (
    input logic         rclk,
    input logic         rrst_n,
    rptr_empty_if.slave bus
);

    localparam int PTR_W = ptr_width(ADDR_WIDTH);

    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] rgray_q;
    logic [PTR_W-1:0] rlevel_q;
    logic             rempty_q;
    logic             ralmost_empty_q;
    logic             runderflow_q;

    logic             rd_en;
    logic [PTR_W-1:0] rbin_next;
    logic [PTR_W-1:0] rgray_next;
    logic [PTR_W-1:0] wbin_sync;
    logic [PTR_W-1:0] level_next;

    always_comb begin
        rd_en      = bus.rinc & ~rempty_q;
        rbin_next  = rbin + PTR_W'(rd_en);
        rgray_next = PTR_W'(bin2gray(MAX_PTR_W'(rbin_next)));
        wbin_sync  = PTR_W'(gray2bin(MAX_PTR_W'(bus.wptr_gray_sync)));
        // Modulo subtraction keeps the level right across the pointer wrap.
        level_next = wbin_sync - rbin_next;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin            <= '0;
            rgray_q         <= '0;
            rlevel_q        <= '0;
            rempty_q        <= 1'b1;
            ralmost_empty_q <= 1'b1;
            runderflow_q    <= 1'b0;
        end else begin
            rbin            <= rbin_next;
            rgray_q         <= rgray_next;
            rlevel_q        <= level_next;
            // Equal Gray pointers (all bits, including the wrap bit) mean empty.
            rempty_q        <= (rgray_next == bus.wptr_gray_sync);
            ralmost_empty_q <= (level_next <= PTR_W'(AE_THRESH));
            runderflow_q    <= bus.rinc & rempty_q;
        end
    end

    assign bus.raddr         = rbin[ADDR_WIDTH-1:0];
    assign bus.rptr_gray     = rgray_q;
    assign bus.rlevel        = rlevel_q;
    assign bus.rempty        = rempty_q;
    assign bus.ralmost_empty = ralmost_empty_q;
    assign bus.runderflow    = runderflow_q;

endmodule

// File: tb/tb_rptr_empty.sv
module tb_rptr_empty;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    rptr_empty_if #(.ADDR_WIDTH(4)) bus ();

    rptr_empty #(.ADDR_WIDTH(4), .AE_THRESH(1)) dut (
        .rclk   (clk),
        .rrst_n (rst_n),
        .bus    (bus)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [4:0] g5(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    // Advance one edge and land 1 time unit after it, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.rinc = 1'b1;
        bus.wptr_gray_sync = 5'b00011;
        repeat (2) tick();
        vectors++; if (bus.rempty !== 1'b1) begin miscompares++; $display("FAIL reset_rempty got=%0b exp=1", bus.rempty); end
        vectors++; if (bus.rlevel !== 5'd0) begin miscompares++; $display("FAIL reset_rlevel got=%0d exp=0", bus.rlevel); end
        vectors++; if (bus.raddr !== 4'd0) begin miscompares++; $display("FAIL reset_raddr got=%0d exp=0", bus.raddr); end
        vectors++; if (bus.rptr_gray !== 5'd0) begin miscompares++; $display("FAIL reset_rptr_gray got=%b exp=00000", bus.rptr_gray); end
        vectors++; if (bus.runderflow !== 1'b0) begin miscompares++; $display("FAIL reset_runderflow got=%0b exp=0", bus.runderflow); end
        vectors++; if (bus.ralmost_empty !== 1'b1) begin miscompares++; $display("FAIL reset_ae got=%0b exp=1", bus.ralmost_empty); end
        bus.rinc = 1'b0;
        bus.wptr_gray_sync = 5'b00000;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill_drain();
        bus.wptr_gray_sync = 5'b00111;   // gray(5)
        tick();
        vectors++; if (bus.rempty !== 1'b0) begin miscompares++; $display("FAIL fill_rempty got=%0b exp=0", bus.rempty); end
        vectors++; if (bus.rlevel !== 5'd5) begin miscompares++; $display("FAIL fill_rlevel got=%0d exp=5", bus.rlevel); end
        vectors++; if (bus.ralmost_empty !== 1'b0) begin miscompares++; $display("FAIL fill_ae got=%0b exp=0", bus.ralmost_empty); end
        for (int i = 0; i < 5; i++) begin
            vectors++; if (bus.raddr !== 4'(i)) begin miscompares++; $display("FAIL drain_raddr got=%0d exp=%0d", bus.raddr, i); end
            bus.rinc = 1'b1;
            tick();
            vectors++; if (bus.rlevel !== 5'(4 - i)) begin miscompares++; $display("FAIL drain_rlevel got=%0d exp=%0d", bus.rlevel, 4 - i); end
        end
        bus.rinc = 1'b0;
        vectors++; if (bus.rempty !== 1'b1) begin miscompares++; $display("FAIL drain_rempty got=%0b exp=1", bus.rempty); end
        vectors++; if (bus.raddr !== 4'd5) begin miscompares++; $display("FAIL drain_raddr_end got=%0d exp=5", bus.raddr); end
        vectors++; if (bus.runderflow !== 1'b0) begin miscompares++; $display("FAIL drain_runderflow got=%0b exp=0", bus.runderflow); end
    endtask

    task automatic test_underflow();
        bus.rinc = 1'b1;
        tick();
        bus.rinc = 1'b0;
        vectors++; if (bus.runderflow !== 1'b1) begin miscompares++; $display("FAIL uf_pulse got=%0b exp=1", bus.runderflow); end
        vectors++; if (bus.raddr !== 4'd5) begin miscompares++; $display("FAIL uf_raddr got=%0d exp=5", bus.raddr); end
        vectors++; if (bus.rptr_gray !== 5'b00111) begin miscompares++; $display("FAIL uf_rptr_gray got=%b exp=00111", bus.rptr_gray); end
        vectors++; if (bus.rempty !== 1'b1) begin miscompares++; $display("FAIL uf_rempty got=%0b exp=1", bus.rempty); end
        tick();
        vectors++; if (bus.runderflow !== 1'b0) begin miscompares++; $display("FAIL uf_pulse_end got=%0b exp=0", bus.runderflow); end
        vectors++; if (bus.raddr !== 4'd5) begin miscompares++; $display("FAIL uf_raddr_hold got=%0d exp=5", bus.raddr); end
    endtask

    task automatic test_almost_empty();
        bus.wptr_gray_sync = 5'b00100;   // gray(7); rbin = 5
        tick();
        vectors++; if (bus.rlevel !== 5'd2) begin miscompares++; $display("FAIL ae_level2 got=%0d exp=2", bus.rlevel); end
        vectors++; if (bus.ralmost_empty !== 1'b0) begin miscompares++; $display("FAIL ae_at2 got=%0b exp=0", bus.ralmost_empty); end
        bus.rinc = 1'b1;
        tick();
        vectors++; if (bus.rlevel !== 5'd1) begin miscompares++; $display("FAIL ae_level1 got=%0d exp=1", bus.rlevel); end
        vectors++; if (bus.ralmost_empty !== 1'b1) begin miscompares++; $display("FAIL ae_at1 got=%0b exp=1", bus.ralmost_empty); end
        vectors++; if (bus.rempty !== 1'b0) begin miscompares++; $display("FAIL ae_rempty1 got=%0b exp=0", bus.rempty); end
        tick();
        vectors++; if (bus.rempty !== 1'b1) begin miscompares++; $display("FAIL ae_rempty0 got=%0b exp=1", bus.rempty); end
        vectors++; if (bus.rlevel !== 5'd0) begin miscompares++; $display("FAIL ae_level0 got=%0d exp=0", bus.rlevel); end
        tick();   // rinc still high, FIFO empty: must not move
        bus.rinc = 1'b0;
        vectors++; if (bus.raddr !== 4'd7) begin miscompares++; $display("FAIL ae_no_extra_read got=%0d exp=7", bus.raddr); end
        tick();
    endtask

    task automatic test_wrap();
        bus.wptr_gray_sync = 5'b10001;   // gray(30); rbin = 7
        tick();
        vectors++; if (bus.rlevel !== 5'd23) begin miscompares++; $display("FAIL wrap_level23 got=%0d exp=23", bus.rlevel); end
        bus.rinc = 1'b1;
        repeat (23) tick();
        bus.rinc = 1'b0;
        vectors++; if (bus.raddr !== 4'd14) begin miscompares++; $display("FAIL wrap_raddr30 got=%0d exp=14", bus.raddr); end
        vectors++; if (bus.rptr_gray !== 5'b10001) begin miscompares++; $display("FAIL wrap_gray30 got=%b exp=10001", bus.rptr_gray); end
        vectors++; if (bus.rempty !== 1'b1) begin miscompares++; $display("FAIL wrap_empty30 got=%0b exp=1", bus.rempty); end
        bus.wptr_gray_sync = 5'b00000;   // wbin 32 mod 32
        tick();
        vectors++; if (bus.rlevel !== 5'd2) begin miscompares++; $display("FAIL wrap_level2 got=%0d exp=2", bus.rlevel); end
        vectors++; if (bus.rempty !== 1'b0) begin miscompares++; $display("FAIL wrap_nonempty got=%0b exp=0", bus.rempty); end
        bus.rinc = 1'b1;
        tick();
        vectors++; if (bus.rptr_gray !== 5'b10000) begin miscompares++; $display("FAIL wrap_gray31 got=%b exp=10000", bus.rptr_gray); end
        vectors++; if (bus.raddr !== 4'd15) begin miscompares++; $display("FAIL wrap_raddr31 got=%0d exp=15", bus.raddr); end
        vectors++; if (bus.ralmost_empty !== 1'b1) begin miscompares++; $display("FAIL wrap_ae got=%0b exp=1", bus.ralmost_empty); end
        tick();
        bus.rinc = 1'b0;
        vectors++; if (bus.rptr_gray !== 5'b00000) begin miscompares++; $display("FAIL wrap_gray0 got=%b exp=00000", bus.rptr_gray); end
        vectors++; if (bus.raddr !== 4'd0) begin miscompares++; $display("FAIL wrap_raddr0 got=%0d exp=0", bus.raddr); end
        vectors++; if (bus.rempty !== 1'b1) begin miscompares++; $display("FAIL wrap_empty0 got=%0b exp=1", bus.rempty); end
    endtask

    task automatic test_simultaneous();
        bus.wptr_gray_sync = 5'b00010;   // gray(3); rbin = 0
        tick();
        vectors++; if (bus.rlevel !== 5'd3) begin miscompares++; $display("FAIL sim_level_pre got=%0d exp=3", bus.rlevel); end
        bus.rinc = 1'b1;
        bus.wptr_gray_sync = 5'b00110;   // gray(4)
        tick();
        bus.rinc = 1'b0;
        vectors++; if (bus.rlevel !== 5'd3) begin miscompares++; $display("FAIL sim_level got=%0d exp=3", bus.rlevel); end
        vectors++; if (bus.rempty !== 1'b0) begin miscompares++; $display("FAIL sim_rempty got=%0b exp=0", bus.rempty); end
        vectors++; if (bus.raddr !== 4'd1) begin miscompares++; $display("FAIL sim_raddr got=%0d exp=1", bus.raddr); end
        vectors++; if (bus.rptr_gray !== 5'b00001) begin miscompares++; $display("FAIL sim_gray got=%b exp=00001", bus.rptr_gray); end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.rempty !== 1'b1) begin miscompares++; $display("FAIL arst_rempty got=%0b exp=1", bus.rempty); end
        vectors++; if (bus.rlevel !== 5'd0) begin miscompares++; $display("FAIL arst_rlevel got=%0d exp=0", bus.rlevel); end
        vectors++; if (bus.raddr !== 4'd0) begin miscompares++; $display("FAIL arst_raddr got=%0d exp=0", bus.raddr); end
        vectors++; if (bus.rptr_gray !== 5'd0) begin miscompares++; $display("FAIL arst_gray got=%b exp=00000", bus.rptr_gray); end
        vectors++; if (bus.ralmost_empty !== 1'b1) begin miscompares++; $display("FAIL arst_ae got=%0b exp=1", bus.ralmost_empty); end
        bus.wptr_gray_sync = 5'b00000;
        rst_n = 1'b1;
        tick();
    endtask

    // Random reads and writes from a clean reset against a small occupancy model.
    task automatic test_gray_random();
        logic [4:0] m_rbin, m_rbin_n, wbin, wbin_n, exp_level, prev_gray;
        logic       m_empty, rinc_v, adv;
        m_rbin  = 5'd0;
        wbin    = 5'd0;
        m_empty = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            rinc_v    = 1'($urandom_range(0, 1));
            m_rbin_n  = m_rbin + 5'(rinc_v & ~m_empty);
            adv       = ($urandom_range(0, 2) != 0) && ((wbin - m_rbin_n) < 5'd16);
            wbin_n    = wbin + 5'(adv);
            prev_gray = bus.rptr_gray;
            bus.rinc  = rinc_v;
            bus.wptr_gray_sync = g5(wbin_n);
            tick();
            m_rbin    = m_rbin_n;
            wbin      = wbin_n;
            exp_level = wbin - m_rbin;
            m_empty   = (exp_level == 5'd0);
            vectors++; if ($countones(prev_gray ^ bus.rptr_gray) > 1) begin miscompares++; $display("FAIL rnd_hamming cycle=%0d got=%b prev=%b", c, bus.rptr_gray, prev_gray); end
            vectors++; if (bus.rlevel !== exp_level) begin miscompares++; $display("FAIL rnd_level cycle=%0d got=%0d exp=%0d", c, bus.rlevel, exp_level); end
            vectors++; if (bus.rempty !== m_empty) begin miscompares++; $display("FAIL rnd_rempty cycle=%0d got=%0b exp=%0b", c, bus.rempty, m_empty); end
        end
        bus.rinc = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.rinc    = 1'b0;
        bus.wptr_gray_sync = 5'b00000;
        test_reset();
        test_fill_drain();
        test_underflow();
        test_almost_empty();
        test_wrap();
        test_simultaneous();
        test_async_reset();
        test_gray_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
